// File: rtl/led_pattern_engine.sv
// Parametrised LED pattern generator: rotate, shift-with-fill, bounce and hold, stepped by a clock-enable divider.
// Optional LED_ACTIVE_LOW_EN drives led as the inverse of the internal pattern.
module led_pattern_engine #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV_VAL   = 3125000,
    parameter int unsigned RESET_PAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             fill,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam int unsigned CNT_W  = $clog2(DIV_VAL);
    localparam int unsigned BCNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] RST_PAT = WIDTH'(RESET_PAT);

    localparam logic [1:0] MODE_ROT    = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    logic [WIDTH-1:0]  pat, pat_nxt, led_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic              bdir, bdir_nxt;
    logic              tick;
    logic [WIDTH-1:0]  rot_l, rot_r;

    assign tick  = en & (cnt == CNT_W'(DIV_VAL - 1));
    assign rot_l = {pat[WIDTH-2:0], pat[WIDTH-1]};
    assign rot_r = {pat[0], pat[WIDTH-1:1]};

    // Next-state for divider, pattern and bounce tracking; load outranks tick.
    always_comb begin
        pat_nxt  = pat;
        cnt_nxt  = cnt;
        bcnt_nxt = bcnt;
        bdir_nxt = bdir;
        if (load) begin
            pat_nxt  = pattern_in;
            cnt_nxt  = '0;
            bcnt_nxt = '0;
            bdir_nxt = dir;
        end else begin
            if (tick) begin
                cnt_nxt = '0;
            end else if (en) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            // Outside bounce, keep the sweep armed from the current dir.
            if (mode != MODE_BOUNCE) begin
                bcnt_nxt = '0;
                bdir_nxt = dir;
            end
            if (tick) begin
                case (mode)
                    MODE_ROT:   pat_nxt = dir ? rot_r : rot_l;
                    MODE_SHIFT: pat_nxt = dir ? {fill, pat[WIDTH-1:1]} : {pat[WIDTH-2:0], fill};
                    MODE_BOUNCE: begin
                        pat_nxt = bdir ? rot_r : rot_l;
                        if (bcnt == BCNT_W'(WIDTH - 2)) begin
                            bcnt_nxt = '0;
                            bdir_nxt = ~bdir;
                        end else begin
                            bcnt_nxt = bcnt + BCNT_W'(1);
                        end
                    end
                    default: pat_nxt = pat;
                endcase
            end
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led_nxt = ~pat_nxt;
`else
    assign led_nxt = pat_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pat  <= RST_PAT;
            cnt  <= '0;
            bcnt <= '0;
            bdir <= 1'b0;
            step <= 1'b0;
`ifdef LED_ACTIVE_LOW_EN
            led  <= ~RST_PAT;
`else
            led  <= RST_PAT;
`endif
        end else begin
            pat  <= pat_nxt;
            cnt  <= cnt_nxt;
            bcnt <= bcnt_nxt;
            bdir <= bdir_nxt;
            step <= tick & ~load;
            led  <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with WIDTH=8, DIV_VAL=4; expectations follow the build's LED polarity.
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rst, en, dir, fill, load;
    logic [1:0] mode;
    logic [7:0] pattern_in;
    logic [7:0] led;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    led_pattern_engine #(.WIDTH(8), .DIV_VAL(4), .RESET_PAT(1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .fill(fill),
        .load(load), .pattern_in(pattern_in), .led(led), .step(step)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_led(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pre quiet cycles with step low, then one edge showing the stepped pattern.
    task automatic do_step(input string tag, input logic [7:0] p, input int pre);
        edges(pre);
        chk({tag, "_quiet"}, 32'(step), 32'd0);
        edges(1);
        chk({tag, "_step"}, 32'(step), 32'd1);
        chk({tag, "_led"}, 32'(led), 32'(exp_led(p)));
    endtask

    logic [7:0] rl [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bn [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] sf [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0; fill = 1'b0;
        load = 1'b0; pattern_in = 8'h00;
        edges(2);
        chk("reset_led", 32'(led), 32'(exp_led(8'h01)));
        chk("reset_step", 32'(step), 32'd0);
        rst = 1'b0;

        // Rotate left full circle, then right.
        for (int i = 0; i < 8; i++) do_step($sformatf("rotl%0d", i), rl[i], 3);
        dir = 1'b1;
        do_step("rotr0", 8'h80, 3);
        do_step("rotr1", 8'h40, 3);

        // Bounce from a loaded single hot bit; dir toggle mid-sweep is ignored.
        load = 1'b1; pattern_in = 8'h01; mode = 2'b10; dir = 1'b0;
        edges(1);
        load = 1'b0;
        chk("bnc_load_led", 32'(led), 32'(exp_led(8'h01)));
        chk("bnc_load_step", 32'(step), 32'd0);
        for (int i = 0; i < 14; i++) begin
            if (i == 3) dir = 1'b1;
            do_step($sformatf("bnc%0d", i), bn[i], 3);
        end

        // Load coinciding with a tick wins and suppresses the step.
        mode = 2'b11;
        edges(3);
        load = 1'b1; pattern_in = 8'hA5;
        edges(1);
        load = 1'b0;
        chk("ldtick_led", 32'(led), 32'(exp_led(8'hA5)));
        chk("ldtick_step", 32'(step), 32'd0);
        do_step("hold", 8'hA5, 3);

        // en low for 10 cycles stretches the interval by exactly 10.
        mode = 2'b00; dir = 1'b0;
        edges(2);
        en = 1'b0;
        edges(10);
        chk("en_off_led", 32'(led), 32'(exp_led(8'hA5)));
        chk("en_off_step", 32'(step), 32'd0);
        en = 1'b1;
        do_step("en_resume", 8'h4B, 1);

        // Bounce toward LSB, then reset mid-sweep restarts toward MSB.
        dir = 1'b1;
        edges(1);
        mode = 2'b10;
        do_step("bncr0", 8'hA5, 2);
        do_step("bncr1", 8'hD2, 3);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("midrst_led", 32'(led), 32'(exp_led(8'h01)));
        chk("midrst_step", 32'(step), 32'd0);
        do_step("postrst0", 8'h02, 3);
        do_step("postrst1", 8'h04, 3);

        // Shift with fill saturates at all ones, then shift right with zero fill.
        load = 1'b1; pattern_in = 8'h00; mode = 2'b01; fill = 1'b1; dir = 1'b0;
        edges(1);
        load = 1'b0;
        chk("sf_load_led", 32'(led), 32'(exp_led(8'h00)));
        for (int i = 0; i < 9; i++) do_step($sformatf("sf%0d", i), sf[i], 3);
        fill = 1'b0; dir = 1'b1;
        do_step("sfr", 8'h7F, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator, the successor to the fixed 16-bit LED rotator. It is a single-clock-domain block: a clock-enable tick replaces the derived divider clock. It adds width and rate parameters, a load port, four modes (rotate, shift-with-fill, bounce, hold), a step strobe, and a compile-time LED polarity option. It sits between the board clock and the LED pins, driven by switches or a control FSM.

## Interface
- WIDTH, 16: pattern and LED width; must be ≥ 2.
- DIV_VAL, 3125000: step period in clk cycles (100 MHz / 32); must be ≥ 2.
- RESET_PAT, 1: pattern register value at reset (WIDTH bits, zero-extended).

- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes the divider and the pattern.
- mode  in  2  00 rotate, 01 shift with fill, 10 bounce, 11 hold.
- dir  in  1  0 = toward MSB (left), 1 = toward LSB (right).
- fill  in  1  bit shifted in during mode 01.
- load  in  1  load pattern_in into the pattern register.
- pattern_in  in  WIDTH  value to load.
- led  out  WIDTH  registered LED drive.
- step  out  1  one-cycle strobe, high in the first cycle a stepped led value is visible.

## Operation
- **Divider**
  - Counter cnt has width $clog2(DIV_VAL) and counts 0..DIV_VAL-1 while en=1.
  - tick = en & (cnt == DIV_VAL-1). On tick, cnt wraps to 0.
  - en=0 holds cnt.
- **Pattern register pat** (all updates are in the same clock edge; priority order):
  1. rst
  2. load
  3. tick
- **On load**
  - pat <= pattern_in and cnt <= 0.
  - Bounce state is cleared: bcnt <= 0, bdir <= dir.
  - load works when en=0.
  - load and tick in the same cycle: load wins, no step.
- **On tick, by mode**
  - 00 rotate: dir=0 gives {pat[W-2:0],pat[W-1]}; dir=1 gives {pat[0],pat[W-1:1]}.
  - 01 shift: dir=0 gives {pat[W-2:0],fill}; dir=1 gives {fill,pat[W-1:1]}.
  - 10 bounce: rotate using bdir, not dir. If bcnt == WIDTH-2, then bcnt <= 0 and bdir <= ~bdir; otherwise bcnt <= bcnt+1. A single hot bit therefore travels end to end and reverses without wrapping.
  - 11 hold: pat unchanged; step is still asserted.
- **Mode and direction sampling**
  - While mode != 10, every cycle: bcnt <= 0 and bdir <= dir. Entering bounce therefore starts from the current dir with a full sweep.
  - mode, dir and fill are sampled only at tick (apart from the bounce tracking above). Changes between ticks have no effect on led.
- **Outputs**
  - led is the registered image of pat (see Configuration).
  - step is registered: step <= tick & ~load.

## Timing
- **Reset** (synchronous, one edge):
  - pat=RESET_PAT, cnt=0, bcnt=0, bdir=0, step=0.
  - led = RESET_PAT, or its inverse with LED_ACTIVE_LOW_EN.
  - Mid-operation rst aborts any sweep. The first tick after release comes DIV_VAL cycles later.
- **Step period**: exactly DIV_VAL cycles with en held high.
- **Latency**: led changes on the edge after tick is computed. step is high in that same cycle.
- **Load latency**: load sampled at edge N gives led = pattern_in after edge N, with step=0. The next tick occurs DIV_VAL cycles after N.
- **en deassert**: takes effect at the next edge. Re-assert resumes from the held cnt; no cycles are lost or added beyond the en=0 gap.
- **Width rules**: all pattern ops are WIDTH bits with no carry. bcnt has width $clog2(WIDTH).

## Configuration
- LED_ACTIVE_LOW_EN
  - **Defined**: led = ~pat, suiting active-low LED boards. With the default RESET_PAT, reset shows a single lit LED at bit 0 (led = all ones except bit 0).
  - **Undefined**: led = pat, active-high.
  - Internal pattern semantics, step and all timing are identical in both builds.

## Test plan
(WIDTH=8, DIV_VAL=4, LED_ACTIVE_LOW_EN defined unless stated.)
- **Reset**: rst for 2 cycles -> led=8'hFE, step=0. First step occurs 4 cycles after release.
- **Rotate**: mode=00, dir=0 -> led steps FE, FD, FB … 7F, FE, with step pulses exactly 4 cycles apart. dir=1 -> FE, 7F, BF.
- **Bounce**: load 8'h01, mode=10, dir=0 -> pat 02, 04 … 80 after 7 ticks, then 40 on the 8th tick and 01 on the 14th tick. Toggling dir mid-sweep has no effect.
- **Shift/fill** (LED_ACTIVE_LOW_EN undefined): load 8'h00, mode=01, fill=1, dir=0 -> led 01, 03, 07 … FF, then stays FF.
- **Load vs tick**: assert load with pattern_in=8'hA5 in a tick cycle -> led=8'h5A next cycle, step=0, next step 4 cycles later.
- **en and reset mid-run**: en=0 for 10 cycles -> led and step frozen, and the step interval stretches by exactly 10 cycles. rst mid-bounce -> led=8'hFE and bounce restarts toward MSB.
